// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared state encoding, sizing constants and FIFO entry layout
package fetch_controller_pkg;

    localparam int ADDR_STRIDE = 2;
    localparam int MAX_BEATS   = 8;
    localparam int BEAT_W      = 15;
    localparam int TAG_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [BEAT_W-1:0] beat1;
        logic [BEAT_W-1:0] beat2;
        logic [TAG_W-1:0]  tag;
    } entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry in-order FIFO of fetched beats with synchronous flush
module fetch_skid_fifo
    import fetch_controller_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
    assign dout  = mem[rd_ptr];

    // store on push, advance the head on pop, drop everything on flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop && !empty)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push && !full} - {1'b0, pop && !empty};
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: burst read sequencer feeding a 2-entry skid FIFO toward the accumulate stage
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_STRIDE = fetch_controller_pkg::ADDR_STRIDE,
    parameter int MAX_BEATS   = fetch_controller_pkg::MAX_BEATS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       base_addr1,
    input  logic [15:0]       base_addr2,
    input  logic [3:0]        length,
    output logic [15:0]       ReadAddress1,
    output logic [15:0]       ReadAddress2,
    output logic              rd_en,
    input  logic [127:0]      ReadBus1,
    input  logic [127:0]      ReadBus2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] AccumlateOut1,
    output logic [BEAT_W-1:0] AccumlateOut2,
    output logic [TAG_W-1:0]  store_count,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [3:0]       len;
    logic [3:0]       issued;
    logic [3:0]       popped;
    logic [TAG_W-1:0] rd_tag;
    entry_t           head;
    entry_t           wr_entry;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             credit;
    logic             can_issue;
    logic [2:0]       entries;
    logic             unused_bus;

    // the read in flight (rd_en high) lands in the FIFO at the end of this cycle
    assign push      = rd_en & ~abort;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign entries   = {1'b0, full, ~full & ~empty};
    assign credit    = entries + {2'b0, rd_en} < 3'd2 + {2'b0, pop};
    assign can_issue = credit && issued < len;
    assign wr_entry  = '{beat1: ReadBus1[BEAT_W-1:0], beat2: ReadBus2[BEAT_W-1:0], tag: rd_tag};
    assign AccumlateOut1 = head.beat1;
    assign AccumlateOut2 = head.beat2;
    assign store_count   = head.tag;
    assign unused_bus    = ^{ReadBus1[127:BEAT_W], ReadBus2[127:BEAT_W]};

    // sequence bursts, issue reads under credit and register all control outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ReadAddress1 <= '0;
            ReadAddress2 <= '0;
            rd_en        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            len          <= '0;
            issued       <= '0;
            popped       <= '0;
            rd_tag       <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        len          <= length > 4'(MAX_BEATS) ? 4'(MAX_BEATS) : length;
                        issued       <= 4'd1;
                        popped       <= '0;
                        rd_tag       <= '0;
                        ReadAddress1 <= base_addr1;
                        ReadAddress2 <= base_addr2;
                        rd_en        <= length != 4'd0;
                        done         <= length == 4'd0;
                        busy         <= 1'b1;
                        state        <= length != 4'd0 ? FETCH : DONE;
                    end
                    FETCH: begin
                        if (can_issue) begin
                            rd_en        <= 1'b1;
                            ReadAddress1 <= ReadAddress1 + 16'(ADDR_STRIDE);
                            ReadAddress2 <= ReadAddress2 + 16'(ADDR_STRIDE);
                            issued       <= issued + 4'd1;
                            rd_tag       <= issued[TAG_W-1:0];
                        end
                        if (rd_en && issued == len)
                            state <= DRAIN;
                    end
                    DRAIN: if (pop && popped + 4'd1 == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
                if (pop)
                    popped <= popped + 4'd1;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (abort),
        .din     (wr_entry),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized bursts checked against a transaction-level model of the fetch path
module tb_fetch_controller;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [15:0]  base_addr1 = '0;
    logic [15:0]  base_addr2 = '0;
    logic [3:0]   length = '0;
    logic [127:0] ReadBus1 = '0;
    logic [127:0] ReadBus2 = '0;
    logic [15:0]  ReadAddress1;
    logic [15:0]  ReadAddress2;
    logic         rd_en;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic [14:0]  AccumlateOut1;
    logic [14:0]  AccumlateOut2;
    logic [2:0]   store_count;

    typedef struct {logic [15:0] a1; logic [15:0] a2;} rd_t;
    typedef struct {logic [14:0] d1; logic [14:0] d2; logic [2:0] tag;} beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    done_cyc = -1;
    int    outstanding = 0;
    bit    active = 1'b0;
    bit    done_due = 1'b0;
    bit    stall_prev = 1'b0;
    rd_t   exp_rd[$];
    beat_t exp_beat[$];
    int    hs_cyc[$];

    always #5 clock = ~clock;

    fetch_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .base_addr1    (base_addr1),
        .base_addr2    (base_addr2),
        .length        (length),
        .ReadAddress1  (ReadAddress1),
        .ReadAddress2  (ReadAddress2),
        .rd_en         (rd_en),
        .ReadBus1      (ReadBus1),
        .ReadBus2      (ReadBus2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .AccumlateOut1 (AccumlateOut1),
        .AccumlateOut2 (AccumlateOut2),
        .store_count   (store_count),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [14:0] d1f(logic [15:0] a);
        return 15'(a ^ 16'h2A55);
    endfunction

    function automatic logic [14:0] d2f(logic [15:0] a);
        return 15'(a * 16'd7 + 16'd3);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // one clock cycle: observe outputs, serve memory, advance the model, move to next negedge
    task automatic tick();
        bit    was_active = active;
        bit    nd = 1'b0;
        bit    hs;
        int    n;
        rd_t   r;
        logic [15:0] a1;
        logic [15:0] a2;
        ReadBus1 = {$urandom, $urandom, $urandom, $urandom};
        ReadBus2 = {$urandom, $urandom, $urandom, $urandom};
        if (rd_en) begin
            ReadBus1[14:0] = d1f(ReadAddress1);
            ReadBus2[14:0] = d2f(ReadAddress2);
        end
        check("busy", busy, active);
        check("done", done, done_due);
        if (done) done_cyc = cyc;
        if (!active) check("idle_valid", out_valid, 0);
        if (stall_prev) check("stall_hold", out_valid, 1);
        if (rd_en) begin
            if (exp_rd.size() == 0) check("rd_extra", rd_en, 0);
            else begin
                r = exp_rd.pop_front();
                check("addr1", ReadAddress1, r.a1);
                check("addr2", ReadAddress2, r.a2);
                outstanding++;
                check("outstanding_le2", outstanding <= 2, 1);
            end
        end
        if (out_valid) begin
            if (exp_beat.size() == 0) check("beat_extra", out_valid, 0);
            else begin
                check("acc1", AccumlateOut1, exp_beat[0].d1);
                check("acc2", AccumlateOut2, exp_beat[0].d2);
                check("tag", store_count, exp_beat[0].tag);
            end
        end
        hs = out_valid && out_ready && !abort && exp_beat.size() != 0;
        stall_prev = out_valid && !out_ready && !abort;
        if (abort) begin
            active = 1'b0;
            exp_rd.delete();
            exp_beat.delete();
            outstanding = 0;
        end else if (done_due) begin
            active = 1'b0;
        end else if (hs) begin
            void'(exp_beat.pop_front());
            outstanding--;
            hs_cyc.push_back(cyc);
            nd = exp_beat.size() == 0;
        end
        if (!was_active && start && !abort) begin
            n = length > 4'd8 ? 8 : int'(length);
            active = 1'b1;
            nd = n == 0;
            start_cyc = cyc;
            hs_cyc.delete();
            for (int k = 0; k < n; k++) begin
                a1 = base_addr1 + 16'(2 * k);
                a2 = base_addr2 + 16'(2 * k);
                exp_rd.push_back('{a1: a1, a2: a2});
                exp_beat.push_back('{d1: d1f(a1), d2: d2f(a2), tag: 3'(k)});
            end
        end
        done_due = nd;
        cyc++;
        @(negedge clock);
    endtask

    task automatic launch(logic [15:0] b1, logic [15:0] b2, logic [3:0] len);
        base_addr1 = b1;
        base_addr2 = b2;
        length = len;
        start = 1'b1;
        abort = 1'b0;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        check("rst_addr", {ReadAddress1, ReadAddress2}, 0);
        check("rst_ctl", {rd_en, out_valid, busy, done, store_count}, 0);
        check("rst_acc", {AccumlateOut1, AccumlateOut2}, 0);
        active = 1'b0;
        done_due = 1'b0;
        stall_prev = 1'b0;
        outstanding = 0;
        exp_rd.delete();
        exp_beat.delete();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_idle(int budget, int ready_pct);
        for (int i = 0; active && i < budget; i++) begin
            out_ready = $urandom_range(0, 99) < ready_pct;
            tick();
        end
        if (active) begin
            check("timeout", busy, 0);
            mid_reset();
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("init_addr", {ReadAddress1, ReadAddress2}, 0);
        check("init_ctl", {rd_en, out_valid, busy, done, store_count}, 0);
        check("init_acc", {AccumlateOut1, AccumlateOut2}, 0);
        reset_n = 1'b1;
        tick();

        launch(16'h0000, 16'h0100, 4'd8);
        run_idle(40, 100);
        check("full_beats", hs_cyc.size(), 8);
        check("first_latency", hs_cyc.size() > 0 ? hs_cyc[0] - start_cyc : -1, 2);
        check("full_span", hs_cyc.size() == 8 ? hs_cyc[7] - hs_cyc[0] : -1, 7);
        check("done_after_last", hs_cyc.size() > 0 ? done_cyc - hs_cyc[hs_cyc.size() - 1] : -1, 1);
        tick();

        launch(16'h1230, 16'h4560, 4'd4);
        for (int r = 1; active && r < 60; r++) begin
            out_ready = !(r >= 3 && r <= 6);
            tick();
        end
        check("bp_beats", hs_cyc.size(), 4);
        check("bp_idle", active, 0);

        launch(16'hFFFC, 16'hFFFE, 4'd4);
        run_idle(40, 100);
        check("wrap_beats", hs_cyc.size(), 4);

        launch(16'h2000, 16'h3000, 4'd0);
        run_idle(5, 100);
        check("zero_done", done_cyc - start_cyc, 1);

        launch(16'h0040, 16'h0080, 4'd12);
        run_idle(40, 100);
        check("clamp_beats", hs_cyc.size(), 8);

        launch(16'h0500, 16'h0600, 4'd8);
        for (int i = 0; hs_cyc.size() < 2 && i < 20; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        launch(16'h0700, 16'h0800, 4'd3);
        run_idle(40, 100);
        check("post_abort_beats", hs_cyc.size(), 3);

        base_addr1 = 16'h0900;
        length = 4'd2;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();

        launch(16'h0A00, 16'h0B00, 4'd8);
        repeat (3) tick();
        mid_reset();
        repeat (2) tick();

        for (int b = 0; b < 60; b++) begin
            launch(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
            for (int i = 0; active && i < 80; i++) begin
                out_ready = $urandom_range(0, 99) < 70;
                abort = $urandom_range(0, 99) < 2;
                start = $urandom_range(0, 99) < 20;
                base_addr1 = 16'($urandom);
                base_addr2 = 16'($urandom);
                length = 4'($urandom);
                tick();
            end
            start = 1'b0;
            abort = 1'b0;
            if (active) begin
                check("rand_timeout", busy, 0);
                mid_reset();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
